// File: rtl/mc8051_mem_sched.sv
// mc8051_mem_sched: machine-cycle phase sequencer that owns the shared memory port
module mc8051_mem_sched #(
  parameter int         WAIT_MAX      = 15,
  parameter logic [7:0] RD_FAULT_DATA = 8'hFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold,
  input  logic [15:0] i_pc,
  input  logic        i_s2_rd_en,
  input  logic        i_s3_rd_en,
  input  logic        i_s5_wr_en,
  input  logic [15:0] i_s2_mem_addr_d,
  input  logic [15:0] i_s3_mem_addr_d,
  input  logic [15:0] i_s5_mem_addr_d,
  input  logic [7:0]  i_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_ready,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [7:0]  o_mem_wdata,
  output logic [3:0]  o_t_p_q,
  output logic [3:0]  o_t_p_d,
  output logic [7:0]  o_s1_instr_buffer,
  output logic [7:0]  o_s2_data_buffer,
  output logic [7:0]  o_s3_data_buffer,
  output logic        o_stall,
  output logic        o_cycle_done,
  output logic        o_timeout_err
);
  localparam logic [3:0] P_RST  = 4'd0;
  localparam logic [3:0] P_S1   = 4'd1;
  localparam logic [3:0] P_S2   = 4'd2;
  localparam logic [3:0] P_S3   = 4'd3;
  localparam logic [3:0] P_S5   = 4'd5;
  localparam logic [3:0] P_S6   = 4'd6;
  localparam logic [3:0] P_HOLD = 4'd7;
  localparam logic [7:0] W_MAX  = 8'(WAIT_MAX);
  logic [3:0] r_t_p_q;
  logic [7:0] r_wait;
  logic [7:0] r_instr;
  logic [7:0] r_s2;
  logic [7:0] r_s3;
  logic       r_err;
  logic       w_rd;
  logic       w_wr;
  logic       w_act;
  logic       w_to;
  logic       w_adv;
  logic [7:0] w_cap;
  logic [3:0] w_next;
  // Decode the access owed by the current phase and decide whether the phase may advance
  always_comb begin
    w_rd   = (r_t_p_q == P_S1) | ((r_t_p_q == P_S2) & i_s2_rd_en) | ((r_t_p_q == P_S3) & i_s3_rd_en);
    w_wr   = (r_t_p_q == P_S5) & i_s5_wr_en;
    w_act  = w_rd | w_wr;
    w_to   = w_act & ~i_mem_ready & (r_wait == W_MAX);
    w_adv  = ~w_act | i_mem_ready | w_to;
    w_cap  = w_to ? RD_FAULT_DATA : i_mem_rdata;
    w_next = (r_t_p_q == P_RST) ? P_S1 :
             (r_t_p_q >= P_S1 && r_t_p_q < P_S6) ? (w_adv ? r_t_p_q + 4'd1 : r_t_p_q) :
             (r_t_p_q == P_S6 || r_t_p_q == P_HOLD) ? (i_hold ? P_HOLD : P_S1) : P_S1;
  end
  // Drive the shared memory port; an idle port parks address and data at zero
  always_comb begin
    o_mem_rd    = w_rd;
    o_mem_wr    = w_wr;
    o_mem_addr  = (r_t_p_q == P_S1) ? i_pc :
                  ((r_t_p_q == P_S2) & i_s2_rd_en) ? i_s2_mem_addr_d :
                  ((r_t_p_q == P_S3) & i_s3_rd_en) ? i_s3_mem_addr_d :
                  w_wr ? i_s5_mem_addr_d : 16'h0000;
    o_mem_wdata = w_wr ? i_mem_wdata : 8'h00;
  end
  // Phase register, wait counter, read-data capture and sticky timeout flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_t_p_q <= P_RST;
      r_wait  <= 8'h00;
      r_instr <= 8'h00;
      r_s2    <= 8'h00;
      r_s3    <= 8'h00;
      r_err   <= 1'b0;
    end else begin
      r_t_p_q <= w_next;
      r_wait  <= w_adv ? 8'h00 : r_wait + 8'h01;
      r_err   <= r_err | w_to;
      if (w_rd & w_adv & (r_t_p_q == P_S1)) r_instr <= w_cap;
      if (w_rd & w_adv & (r_t_p_q == P_S2)) r_s2 <= w_cap;
      if (w_rd & w_adv & (r_t_p_q == P_S3)) r_s3 <= w_cap;
    end
  end
  assign o_t_p_q           = r_t_p_q;
  assign o_t_p_d           = w_next;
  assign o_s1_instr_buffer = r_instr;
  assign o_s2_data_buffer  = r_s2;
  assign o_s3_data_buffer  = r_s3;
  assign o_stall           = w_act & ~w_adv;
  assign o_cycle_done      = (r_t_p_q == P_S6);
  assign o_timeout_err     = r_err;
endmodule

// File: tb/tb_mc8051_mem_sched.sv
// tb_mc8051_mem_sched: directed and random checks of the phase sequencer against a behavioural model
module tb_mc8051_mem_sched;
  localparam int WM = 15;
  logic clk = 0, rst = 1, hold = 0, s2en = 0, s3en = 0, s5en = 0, ready = 0;
  logic [15:0] pc = 0, a2 = 0, a3 = 0, a5 = 0;
  logic [7:0] wd = 0, rdata = 0;
  logic [15:0] addr;
  logic mrd, mwr, stall, done, err;
  logic [7:0] mwd, ins, b2, b3;
  logic [3:0] q, d;
  int total = 0, bad = 0;
  int m_ph = 0, m_wait = 0, nph = 0;
  logic [7:0] m_ins = 0, m_s2 = 0, m_s3 = 0;
  logic m_err = 0, m_valid = 0;
  logic e_rd, e_wr, e_to, e_adv;
  logic s_done, s_stall, s_rd, s_wr;
  logic [3:0] s_q;
  logic [15:0] s_addr;
  logic [7:0] s_wd;
  mc8051_mem_sched #(.WAIT_MAX(WM), .RD_FAULT_DATA(8'hFF)) dut (
    .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_pc(pc),
    .i_s2_rd_en(s2en), .i_s3_rd_en(s3en), .i_s5_wr_en(s5en),
    .i_s2_mem_addr_d(a2), .i_s3_mem_addr_d(a3), .i_s5_mem_addr_d(a5),
    .i_mem_wdata(wd), .i_mem_rdata(rdata), .i_mem_ready(ready),
    .o_mem_addr(addr), .o_mem_rd(mrd), .o_mem_wr(mwr), .o_mem_wdata(mwd),
    .o_t_p_q(q), .o_t_p_d(d), .o_s1_instr_buffer(ins), .o_s2_data_buffer(b2),
    .o_s3_data_buffer(b3), .o_stall(stall), .o_cycle_done(done), .o_timeout_err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic cyc();
    logic [7:0] v;
    @(negedge clk);
    e_rd  = m_ph == 1 || (m_ph == 2 && s2en) || (m_ph == 3 && s3en);
    e_wr  = m_ph == 5 && s5en;
    e_to  = (e_rd || e_wr) && !ready && m_wait == WM;
    e_adv = !(e_rd || e_wr) || ready || e_to;
    if (m_ph == 0) nph = 1;
    else if (m_ph >= 1 && m_ph <= 5) nph = e_adv ? m_ph + 1 : m_ph;
    else if (m_ph == 6 || m_ph == 7) nph = hold ? 7 : 1;
    else nph = 1;
    s_q = q; s_done = done; s_stall = stall; s_rd = mrd; s_wr = mwr; s_addr = addr; s_wd = mwd;
    if (m_valid) begin
      chk("phase_q", q, m_ph);
      chk("phase_d", d, nph);
      chk("mem_rd", mrd, e_rd);
      chk("mem_wr", mwr, e_wr);
      chk("mem_addr", addr, e_rd ? (m_ph == 1 ? pc : m_ph == 2 ? a2 : a3) : e_wr ? a5 : 16'h0);
      chk("mem_wdata", mwd, e_wr ? wd : 8'h0);
      chk("stall", stall, (e_rd || e_wr) && !e_adv);
      chk("cycle_done", done, m_ph == 6);
      chk("instr_buf", ins, m_ins);
      chk("s2_buf", b2, m_s2);
      chk("s3_buf", b3, m_s3);
      chk("timeout_err", err, m_err);
    end
    @(posedge clk);
    if (rst) begin
      m_ph = 0; m_wait = 0; m_ins = 0; m_s2 = 0; m_s3 = 0; m_err = 0; m_valid = 1;
    end else begin
      v = e_to ? 8'hFF : rdata;
      if (e_rd && e_adv) begin
        if (m_ph == 1) m_ins = v;
        else if (m_ph == 2) m_s2 = v;
        else m_s3 = v;
      end
      if (e_to) m_err = 1;
      m_wait = e_adv ? 0 : m_wait + 1;
      m_ph = nph;
    end
    #1;
  endtask
  initial begin
    int seq[7] = '{1, 2, 3, 4, 5, 6, 1};
    int n, w, st, pc_, c2, ok, rd5, c7, h7, after3, strb7, rp;
    cyc(); cyc();
    chk("rst_q", q, 0); chk("rst_ins", ins, 0); chk("rst_err", err, 0);
    chk("rst_strobes", {mrd, mwr}, 0);
    rst = 0; ready = 1; pc = 16'h0100; rdata = 8'h74;
    for (int i = 0; i < 7; i++) begin cyc(); chk("seq", q, seq[i]); end
    chk("fetch_74", ins, 8'h74);
    n = 0;
    for (int i = 0; i < 12; i++) begin cyc(); n += s_done; end
    chk("done_per_6", n, 2);
    s2en = 1; a2 = 16'h0030; rdata = 8'h5A; n = 0; w = 0; st = 0; c2 = 0;
    do begin
      ready = (m_ph != 2) || (w >= 3);
      if (m_ph == 2) w++;
      cyc(); n++; st += s_stall; c2 += (s_q == 2);
    end while (m_ph != 1 && n < 50);
    chk("s2_cycle_len", n, 9); chk("s2_stalls", st, 3); chk("s2_len", c2, 4);
    chk("s2_data", b2, 8'h5A);
    s2en = 0; s5en = 1; a5 = 16'h0040; wd = 8'hC3; n = 0; w = 0; pc_ = 0; c2 = 0; ok = 0; rd5 = 0;
    do begin
      ready = (m_ph != 5) || (w >= 2);
      if (m_ph == 5) w++;
      cyc(); n++; pc_ += s_wr; c2 += (s_q == 5); rd5 += (s_q == 5 && s_rd);
      ok += (s_wr && s_q == 5 && s_addr == 16'h0040 && s_wd == 8'hC3);
    end while (m_ph != 1 && n < 50);
    chk("wr_cycles", pc_, 3); chk("s5_len", c2, 3); chk("wr_stable", ok, 3);
    chk("s5_no_rd", rd5, 0); chk("wr_cycle_len", n, 8);
    s5en = 0; s3en = 1; a3 = 16'h1234; n = 0; c2 = 0;
    do begin
      ready = (m_ph != 3);
      cyc(); n++; c2 += (s_q == 3);
    end while (m_ph != 1 && n < 60);
    chk("s3_timeout_len", c2, 16); chk("s3_fault_data", b3, 8'hFF); chk("timeout_set", err, 1);
    s3en = 0; ready = 1;
    for (int i = 0; i < 6; i++) cyc();
    chk("timeout_sticky", err, 1);
    n = 0; h7 = 0; c7 = 0; after3 = -1; strb7 = 0;
    do begin
      hold = (m_ph == 3) || (m_ph == 6) || (m_ph == 7 && h7 < 4);
      if (m_ph == 7) h7++;
      cyc(); n++;
      if (s_q == 3) after3 = q;
      c7 += (s_q == 7); strb7 += (s_q == 7 && (s_rd || s_wr));
    end while (!(s_q == 7 && m_ph == 1) && n < 60);
    hold = 0;
    chk("hold_s3_ignored", after3, 4); chk("hold_len", c7, 5);
    chk("hold_no_strobe", strb7, 0); chk("hold_exit_s1", q, 1);
    s2en = 1; n = 0;
    while (m_ph != 2 && n < 20) begin ready = 1; cyc(); n++; end
    ready = 0; cyc(); cyc();
    chk("pre_rst_stall", stall, 1);
    rst = 1; cyc();
    chk("midrst_q", q, 0); chk("midrst_strobes", {mrd, mwr}, 0); chk("midrst_s2", b2, 8'h00);
    rst = 0; s2en = 0; ready = 1; cyc();
    chk("midrst_s1", q, 1);
    rp = 80;
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) begin
        case ($urandom_range(0, 3))
          0: rp = 0;
          1: rp = 40;
          2: rp = 85;
          default: rp = 100;
        endcase
      end
      rst = ($urandom_range(0, 299) == 0);
      hold = ($urandom_range(0, 3) == 0);
      s2en = $urandom_range(0, 1); s3en = $urandom_range(0, 1); s5en = $urandom_range(0, 1);
      pc = 16'($urandom); a2 = 16'($urandom); a3 = 16'($urandom); a5 = 16'($urandom);
      wd = 8'($urandom); rdata = 8'($urandom);
      ready = ($urandom_range(0, 99) < rp);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
